coin_acceptor_front_end: RTL and testbench

//   Upstream stage of the vending machine. Conditions three raw coin-sensor lines (nickel,

---
 rtl/vm_pkg.sv | 23 ++
 rtl/coin_debouncer.sv | 43 ++++
 rtl/coin_acceptor_front_end.sv | 82 ++++++++
 tb/tb_coin_acceptor_front_end.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - coin unit values, channel indices and credit types shared by the coin front end
package vm_pkg;

  localparam int NICKEL_UNITS  = 1;
  localparam int DIME_UNITS    = 2;
  localparam int QUARTER_UNITS = 5;

  localparam int CH_NICKEL  = 0;
  localparam int CH_DIME    = 1;
  localparam int CH_QUARTER = 2;

  // Credit carried by a single coin, in nickel units
  typedef logic [2:0] unit_t;

  function automatic unit_t channel_units(input int ch);
    case (ch)
      CH_QUARTER: channel_units = unit_t'(QUARTER_UNITS);
      CH_DIME:    channel_units = unit_t'(DIME_UNITS);
      default:    channel_units = unit_t'(NICKEL_UNITS);
    endcase
  endfunction

endpackage

// File: rtl/coin_debouncer.sv
// rtl/coin_debouncer.sv - two-flop synchronizer, level debouncer and registered rising-edge event
module coin_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic sense,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] count;

  // The counter must actually reach DEBOUNCE_CYCLES before stable flips, so a change
  // needs DEBOUNCE_CYCLES+1 consecutive mismatching synced samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      count  <= '0;
      rise   <= 1'b0;
    end else begin
      sync1 <= sense;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == stable) begin
        count <= '0;
      end else if (count == CNT_W'(DEBOUNCE_CYCLES)) begin
        stable <= sync2;
        count  <= '0;
        rise   <= sync2;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/coin_acceptor_front_end.sv
// rtl/coin_acceptor_front_end.sv - debounces coin sensors, buffers credit, emits spaced dime/nickel pulses
module coin_acceptor_front_end
  import vm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_PENDING     = 15,
  parameter int CREDIT_W        = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                nickel_sense,
  input  logic                dime_sense,
  input  logic                quarter_sense,
  input  logic                accept_enable,
  output logic                nickel_valid,
  output logic                dime_valid,
  output logic [2:0]          coin_reject,
  output logic [CREDIT_W-1:0] pending_credit,
  output logic                busy
);

  localparam int SUM_W = CREDIT_W + 3;

  logic [2:0]       sense_bus;
  logic [2:0]       coin_event;
  logic             last_pulse;
  logic [SUM_W-1:0] accepted;
  logic [2:0]       reject_next;
  logic             emit_fire;
  logic             emit_dime;
  logic [SUM_W-1:0] emitted;
  logic [SUM_W-1:0] pending_next;

  assign sense_bus = {quarter_sense, dime_sense, nickel_sense};

  for (genvar ch = 0; ch < 3; ch++) begin : g_debounce
    coin_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
      .clock (clock),
      .reset (reset),
      .sense (sense_bus[ch]),
      .rise  (coin_event[ch])
    );
  end

  // Room is judged against the current buffer only; a pulse leaving this cycle frees nothing yet.
  always_comb begin
    accepted    = '0;
    reject_next = '0;
    for (int ch = CH_QUARTER; ch >= CH_NICKEL; ch--) begin
      if (coin_event[ch]) begin
        if (SUM_W'(pending_credit) + accepted + SUM_W'(channel_units(ch)) <= SUM_W'(MAX_PENDING))
          accepted = accepted + SUM_W'(channel_units(ch));
        else
          reject_next[ch] = 1'b1;
      end
    end
  end

  assign emit_fire    = accept_enable && (pending_credit != '0) && !last_pulse;
  assign emit_dime    = emit_fire && (pending_credit >= CREDIT_W'(2));
  assign emitted      = emit_dime ? SUM_W'(2) : (emit_fire ? SUM_W'(1) : '0);
  assign pending_next = SUM_W'(pending_credit) + accepted - emitted;

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_credit <= '0;
      last_pulse     <= 1'b0;
      nickel_valid   <= 1'b0;
      dime_valid     <= 1'b0;
      coin_reject    <= '0;
    end else begin
      pending_credit <= pending_next[CREDIT_W-1:0];
      last_pulse     <= emit_fire;
      nickel_valid   <= emit_fire && !emit_dime;
      dime_valid     <= emit_dime;
      coin_reject    <= reject_next;
    end
  end

  assign busy = (pending_credit != '0);

endmodule

// File: tb/tb_coin_acceptor_front_end.sv
// tb/tb_coin_acceptor_front_end.sv - scoreboard bench for the coin acceptor front end
module tb_coin_acceptor_front_end;

  localparam int D    = 4;
  localparam int MAXP = 15;
  localparam int CW   = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          nickel_sense;
  logic          dime_sense;
  logic          quarter_sense;
  logic          accept_enable;
  logic          nickel_valid;
  logic          dime_valid;
  logic [2:0]    coin_reject;
  logic [CW-1:0] pending_credit;
  logic          busy;

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic       prev_pulse = 1'b0;
  int         exp_pulse[$];
  logic [2:0] exp_reject[$];
  int         pulse_cyc[$];

  coin_acceptor_front_end #(
    .DEBOUNCE_CYCLES (D),
    .MAX_PENDING     (MAXP),
    .CREDIT_W        (CW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .nickel_sense   (nickel_sense),
    .dime_sense     (dime_sense),
    .quarter_sense  (quarter_sense),
    .accept_enable  (accept_enable),
    .nickel_valid   (nickel_valid),
    .dime_valid     (dime_valid),
    .coin_reject    (coin_reject),
    .pending_credit (pending_credit),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  // Advance one clock, then sample mid-cycle and consume scoreboard entries for any output seen.
  task automatic tick();
    int         got;
    int         e;
    logic [2:0] er;
    logic       pulse;
    @(posedge clock);
    #4;
    cyc++;
    pulse = nickel_valid | dime_valid;
    if (nickel_valid && dime_valid) begin
      checks++; errors++;
      $display("FAIL both_pulses cycle %0d: nickel_valid=1 dime_valid=1, required at most one", cyc);
    end
    if (pulse && prev_pulse) begin
      checks++; errors++;
      $display("FAIL pulse_gap cycle %0d: pulses on consecutive cycles, required idle gap", cyc);
    end
    if (pulse) begin
      checks++;
      got = dime_valid ? 2 : 1;
      pulse_cyc.push_back(cyc);
      if (exp_pulse.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cycle %0d: got %0d units, required none", cyc, got);
      end else begin
        e = exp_pulse.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL pulse_value cycle %0d: got %0d units, required %0d", cyc, got, e);
        end
      end
    end
    if (coin_reject !== 3'b000) begin
      checks++;
      if (exp_reject.size() == 0) begin
        errors++;
        $display("FAIL unexpected_reject cycle %0d: got %b, required 000", cyc, coin_reject);
      end else begin
        er = exp_reject.pop_front();
        if (coin_reject !== er) begin
          errors++;
          $display("FAIL reject_value cycle %0d: got %b, required %b", cyc, coin_reject, er);
        end
      end
    end
    if (busy !== (pending_credit != '0)) begin
      checks++; errors++;
      $display("FAIL busy cycle %0d: busy=%b pending=%0d", cyc, busy, pending_credit);
    end
    prev_pulse = pulse;
  endtask

  task automatic insert(input logic [2:0] mask);
    {quarter_sense, dime_sense, nickel_sense} = mask;
    repeat (8) tick();
    {quarter_sense, dime_sense, nickel_sense} = 3'b000;
    repeat (10) tick();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 80 && (exp_pulse.size() != 0 || exp_reject.size() != 0); i++) tick();
    repeat (4) tick();
    checks++;
    if (exp_pulse.size() != 0 || exp_reject.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d pulses and %0d rejects outstanding, required 0",
               name, exp_pulse.size(), exp_reject.size());
    end
  endtask

  task automatic expect_pending(input string name, input int value);
    checks++;
    if (pending_credit !== CW'(value)) begin
      errors++;
      $display("FAIL %s: pending_credit=%0d, required %0d", name, pending_credit, value);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    {quarter_sense, dime_sense, nickel_sense} = 3'b000;
    accept_enable = 1'b0;
    repeat (3) tick();
    checks++;
    if ({nickel_valid, dime_valid, coin_reject, pending_credit, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: nv=%b dv=%b rej=%b pend=%0d busy=%b, required all 0",
               nickel_valid, dime_valid, coin_reject, pending_credit, busy);
    end
    reset = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_nickel();
    accept_enable = 1'b1;
    exp_pulse.push_back(1);
    nickel_sense = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      expect_pending($sformatf("nickel_latency_t%0d", c), (c < 7) ? 0 : 1);
    end
    nickel_sense = 1'b0;
    drain("nickel");
    expect_pending("nickel_final", 0);
  endtask

  task automatic test_quarter_split();
    accept_enable = 1'b1;
    pulse_cyc.delete();
    exp_pulse.push_back(2);
    exp_pulse.push_back(2);
    exp_pulse.push_back(1);
    insert(3'b100);
    drain("quarter");
    checks++;
    if (pulse_cyc.size() != 3) begin
      errors++;
      $display("FAIL quarter_pulse_count: got %0d pulses, required 3", pulse_cyc.size());
    end else if (pulse_cyc[1] - pulse_cyc[0] != 2 || pulse_cyc[2] - pulse_cyc[1] != 2) begin
      errors++;
      $display("FAIL quarter_spacing: gaps %0d and %0d, required 2 and 2",
               pulse_cyc[1] - pulse_cyc[0], pulse_cyc[2] - pulse_cyc[1]);
    end
    expect_pending("quarter_final", 0);
  endtask

  task automatic test_bounce();
    logic [3:0] pattern;
    accept_enable = 1'b1;
    pattern = 4'b0101;
    exp_pulse.push_back(2);
    for (int i = 0; i < 4; i++) begin
      dime_sense = pattern[i];
      tick();
    end
    insert(3'b010);
    drain("bounce");
    expect_pending("bounce_dime_final", 0);
    nickel_sense = 1'b1;
    repeat (3) tick();
    nickel_sense = 1'b0;
    repeat (12) tick();
    drain("short_glitch");
    expect_pending("short_glitch_pending", 0);
  endtask

  task automatic test_overflow();
    accept_enable = 1'b0;
    insert(3'b100);
    expect_pending("fill_5", 5);
    insert(3'b100);
    expect_pending("fill_10", 10);
    insert(3'b100);
    expect_pending("fill_15", 15);
    exp_reject.push_back(3'b001);
    insert(3'b001);
    expect_pending("full_nickel_held", 15);
    drain("overflow_reject");
    for (int i = 0; i < 7; i++) exp_pulse.push_back(2);
    exp_pulse.push_back(1);
    accept_enable = 1'b1;
    drain("overflow_empty");
    expect_pending("overflow_final", 0);
  endtask

  task automatic test_same_cycle();
    accept_enable = 1'b0;
    insert(3'b100);
    insert(3'b100);
    insert(3'b010);
    insert(3'b001);
    expect_pending("build_13", 13);
    exp_reject.push_back(3'b100);
    insert(3'b110);
    expect_pending("priority_15", 15);
    drain("same_cycle");
  endtask

  task automatic test_reset_midflight();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    expect_pending("clear_before_build", 0);
    accept_enable = 1'b0;
    insert(3'b100);
    insert(3'b001);
    expect_pending("build_6", 6);
    exp_pulse.push_back(2);
    accept_enable = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({nickel_valid, dime_valid, coin_reject, pending_credit, busy} !== '0) begin
      errors++;
      $display("FAIL midflight_reset: nv=%b dv=%b rej=%b pend=%0d busy=%b, required all 0",
               nickel_valid, dime_valid, coin_reject, pending_credit, busy);
    end
    reset = 1'b0;
    repeat (20) tick();
    expect_pending("after_reset_pending", 0);
    drain("midflight");
  endtask

  initial begin
    test_reset();
    test_nickel();
    test_quarter_split();
    test_bounce();
    test_overflow();
    test_same_cycle();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
